ervp_axi_read_beat_responder: RTL and testbench

ERVP_AXI_READ_BEAT_RESPONDER -- requirements
Module: ervp_axi_read_beat_responder

---
 rtl/ervp_axi_define_pkg.sv | 9 +
 rtl/ervp_axi_read_beat_responder_fifo.sv | 58 +++++
 rtl/ervp_axi_read_beat_responder.sv | 115 +++++++++++
 tb/tb_ervp_axi_read_beat_responder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ervp_axi_define_pkg.sv
// Shared AXI definitions: response width and response codes used by AXI slaves.
package ervp_axi_define_pkg;

    localparam int BW_AXI_RESP = 2;

    localparam logic [BW_AXI_RESP-1:0] AXI_RESPONSE_OKAY   = 2'b00;
    localparam logic [BW_AXI_RESP-1:0] AXI_RESPONSE_SLVERR = 2'b10;

endpackage

// File: rtl/ervp_axi_read_beat_responder_fifo.sv
// ervp_small_fifo: power-of-two circular buffer with registered pointers and
// occupancy; head entry is presented directly from storage.
module ervp_small_fifo #(
    parameter int BW_DATA = 8,
    parameter int DEPTH   = 4,
    localparam int BW_PTR = $clog2(DEPTH),
    localparam int BW_CNT = BW_PTR + 1
) (
    input  logic               clk,
    input  logic               rstnn,
    input  logic               push,
    input  logic [BW_DATA-1:0] push_data,
    input  logic               pop,
    output logic               valid,
    output logic [BW_DATA-1:0] head_data,
    output logic [BW_CNT-1:0]  count
);

    logic [BW_DATA-1:0] storage_r [DEPTH];
    logic [BW_PTR-1:0]  wr_ptr_r;
    logic [BW_PTR-1:0]  rd_ptr_r;
    logic [BW_CNT-1:0]  count_r;
    logic               pop_ok_s;

    assign pop_ok_s  = pop & (count_r != {BW_CNT{1'b0}});
    assign valid     = (count_r != {BW_CNT{1'b0}});
    assign head_data = storage_r[rd_ptr_r];
    assign count     = count_r;

    // Entry storage; contents are don't-care until written, so it is not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            storage_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rstnn) begin
            wr_ptr_r <= {BW_PTR{1'b0}};
            rd_ptr_r <= {BW_PTR{1'b0}};
            count_r  <= {BW_CNT{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + BW_PTR'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + BW_PTR'(1);
            end
            case ({push, pop_ok_s})
                2'b10:   count_r <= count_r + BW_CNT'(1);
                2'b01:   count_r <= count_r - BW_CNT'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ervp_axi_read_beat_responder.sv
// AXI read beat responder: turns accepted beat addresses into memory reads and
// buffers the responses in order for the R channel, with credit-based flow control.
module ervp_axi_read_beat_responder
    import ervp_axi_define_pkg::*;
#(
    parameter int BW_ADDR    = 32,
    parameter int BW_DATA    = 32,
    parameter int BW_ID      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_SIZE   = 4096
) (
    input  logic                   clk,
    input  logic                   rstnn,
    input  logic                   beat_valid,
    input  logic [BW_ADDR-1:0]     beat_addr,
    input  logic [BW_ID-1:0]       beat_id,
    input  logic                   beat_last,
    output logic                   beat_ready,
    output logic                   mem_req,
    output logic [BW_ADDR-1:0]     mem_addr,
    input  logic [BW_DATA-1:0]     mem_rdata,
    output logic                   rvalid,
    output logic [BW_DATA-1:0]     rdata,
    output logic [BW_ID-1:0]       rid,
    output logic [BW_AXI_RESP-1:0] rresp,
    output logic                   rlast,
    input  logic                   rready
);

    localparam int BW_PTR   = $clog2(FIFO_DEPTH);
    localparam int BW_CNT   = BW_PTR + 1;
    localparam int BW_ENTRY = BW_ID + 1 + BW_DATA + BW_AXI_RESP;
    localparam logic [BW_ADDR:0] MEM_LIMIT   = (BW_ADDR+1)'(MEM_SIZE);
    localparam logic [BW_CNT:0]  DEPTH_LIMIT = (BW_CNT+1)'(FIFO_DEPTH);

    logic                   inflight_r;
    logic [BW_ID-1:0]       inflight_id_r;
    logic                   inflight_last_r;
    logic                   inflight_err_r;

    logic [BW_CNT-1:0]      fifo_count_s;
    logic                   fifo_valid_s;
    logic [BW_ENTRY-1:0]    fifo_head_s;
    logic [BW_ENTRY-1:0]    push_data_s;
    logic [BW_CNT:0]        credit_sum_s;
    logic                   accept_s;
    logic                   addr_err_s;
    logic [BW_DATA-1:0]     resp_data_s;
    logic [BW_AXI_RESP-1:0] resp_code_s;

    // Credit check counts the inflight beat so its push can never find the buffer full.
    always_comb begin
        credit_sum_s = {1'b0, fifo_count_s} + {{BW_CNT{1'b0}}, inflight_r};
        beat_ready   = (credit_sum_s < DEPTH_LIMIT);
    end

    // Accept decode and memory request; reset suppresses any request.
    always_comb begin
        addr_err_s = ({1'b0, beat_addr} >= MEM_LIMIT);
        accept_s   = rstnn & beat_valid & beat_ready;
        mem_req    = accept_s & ~addr_err_s;
        mem_addr   = beat_addr;
    end

    // Inflight stage: remembers beat attributes while the memory read completes.
    always_ff @(posedge clk) begin
        if (!rstnn) begin
            inflight_r      <= 1'b0;
            inflight_id_r   <= {BW_ID{1'b0}};
            inflight_last_r <= 1'b0;
            inflight_err_r  <= 1'b0;
        end else begin
            inflight_r <= accept_s;
            if (accept_s) begin
                inflight_id_r   <= beat_id;
                inflight_last_r <= beat_last;
                inflight_err_r  <= addr_err_s;
            end else begin
                inflight_id_r   <= inflight_id_r;
                inflight_last_r <= inflight_last_r;
                inflight_err_r  <= inflight_err_r;
            end
        end
    end

    // Out-of-range beats return zero data with SLVERR instead of stale read data.
    always_comb begin
        if (inflight_err_r) begin
            resp_data_s = {BW_DATA{1'b0}};
            resp_code_s = AXI_RESPONSE_SLVERR;
        end else begin
            resp_data_s = mem_rdata;
            resp_code_s = AXI_RESPONSE_OKAY;
        end
        push_data_s = {inflight_id_r, inflight_last_r, resp_data_s, resp_code_s};
    end

    ervp_small_fifo #(
        .BW_DATA (BW_ENTRY),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstnn     (rstnn),
        .push      (inflight_r),
        .push_data (push_data_s),
        .pop       (rvalid & rready),
        .valid     (fifo_valid_s),
        .head_data (fifo_head_s),
        .count     (fifo_count_s)
    );

    assign rvalid                     = fifo_valid_s;
    assign {rid, rlast, rdata, rresp} = fifo_head_s;

endmodule

// File: tb/tb_ervp_axi_read_beat_responder.sv
// Directed self-checking bench for ervp_axi_read_beat_responder (default parameters).
module tb_ervp_axi_read_beat_responder;

    logic        clk;
    logic        rstnn;
    logic        beat_valid;
    logic [31:0] beat_addr;
    logic [3:0]  beat_id;
    logic        beat_last;
    logic        beat_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rready;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [3:0]  mon_id   [$];
    logic        mon_last [$];
    logic [31:0] mon_data [$];
    logic [1:0]  mon_resp [$];
    int          mon_cyc  [$];

    ervp_axi_read_beat_responder dut (
        .clk        (clk),
        .rstnn      (rstnn),
        .beat_valid (beat_valid),
        .beat_addr  (beat_addr),
        .beat_id    (beat_id),
        .beat_last  (beat_last),
        .beat_ready (beat_ready),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .rid        (rid),
        .rresp      (rresp),
        .rlast      (rlast),
        .rready     (rready)
    );

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return a ^ 32'h0000_A5B5;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model with one-cycle read latency, plus R-channel monitor.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_req) mem_rdata <= mem_model(mem_addr);
        if (rstnn && rvalid && rready) begin
            mon_id.push_back(rid);
            mon_last.push_back(rlast);
            mon_data.push_back(rdata);
            mon_resp.push_back(rresp);
            mon_cyc.push_back(cyc);
        end
    end

    task automatic idle();
        beat_valid = 1'b0;
        beat_addr  = 32'h0;
        beat_id    = 4'h0;
        beat_last  = 1'b0;
    endtask

    task automatic drive(input logic [31:0] a, input logic [3:0] id, input logic last);
        beat_valid = 1'b1;
        beat_addr  = a;
        beat_id    = id;
        beat_last  = last;
    endtask

    task automatic clear_mon();
        mon_id.delete();
        mon_last.delete();
        mon_data.delete();
        mon_resp.delete();
        mon_cyc.delete();
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k;
        k = 0;
        while (mon_id.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        rstnn  = 1'b0;
        rready = 1'b1;
        mem_rdata = 32'h0;
        drive(32'h20, 4'h1, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        n_vec++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
        n_vec++; if (dut.fifo_count_s !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", dut.fifo_count_s); end
        idle();
        rstnn = 1'b1;
        @(negedge clk); #1;
        n_vec++; if (beat_ready !== 1'b1) begin n_err++; $display("FAIL reset_beat_ready: got %b expected 1", beat_ready); end
        n_vec++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid_after: got %b expected 0", rvalid); end
    endtask

    task automatic test_single();
        int a;
        clear_mon();
        rready = 1'b1;
        @(negedge clk);
        a = cyc;
        drive(32'h10, 4'h3, 1'b1);
        #1;
        n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL single_mem_req: got %b expected 1", mem_req); end
        n_vec++; if (mem_addr !== 32'h10) begin n_err++; $display("FAIL single_mem_addr: got %h expected 00000010", mem_addr); end
        @(negedge clk); idle(); #1;
        n_vec++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL single_rvalid_c1: got %b expected 0", rvalid); end
        @(negedge clk); #1;
        n_vec++; if (rvalid !== 1'b1) begin n_err++; $display("FAIL single_rvalid_c2: got %b expected 1", rvalid); end
        n_vec++; if (rdata !== 32'h0000_A5A5) begin n_err++; $display("FAIL single_rdata: got %h expected 0000a5a5", rdata); end
        n_vec++; if (rid !== 4'h3) begin n_err++; $display("FAIL single_rid: got %h expected 3", rid); end
        n_vec++; if (rresp !== 2'b00) begin n_err++; $display("FAIL single_rresp: got %b expected 00", rresp); end
        n_vec++; if (rlast !== 1'b1) begin n_err++; $display("FAIL single_rlast: got %b expected 1", rlast); end
        @(negedge clk); #1;
        n_vec++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL single_rvalid_c3: got %b expected 0", rvalid); end
        n_vec++; if (mon_id.size() !== 1) begin n_err++; $display("FAIL single_count: got %0d expected 1", mon_id.size()); end
        for (int i = 0; i < mon_cyc.size(); i++) begin
            n_vec++; if (mon_cyc[i] !== a + 2) begin n_err++; $display("FAIL single_latency: got cycle %0d expected %0d", mon_cyc[i], a + 2); end
        end
    endtask

    task automatic test_stream();
        int a;
        clear_mon();
        rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) a = cyc;
            drive(32'(i * 4), 4'(i), (i == 3));
            #1;
            n_vec++; if (beat_ready !== 1'b1) begin n_err++; $display("FAIL stream_beat_ready[%0d]: got %b expected 1", i, beat_ready); end
        end
        @(negedge clk); idle();
        #1;
        n_vec++; if (beat_ready !== 1'b1) begin n_err++; $display("FAIL stream_beat_ready_tail: got %b expected 1", beat_ready); end
        wait_beats(4, 20);
        n_vec++; if (mon_id.size() !== 4) begin n_err++; $display("FAIL stream_count: got %0d expected 4", mon_id.size()); end
        for (int i = 0; i < mon_id.size(); i++) begin
            n_vec++; if (mon_data[i] !== mem_model(32'(i * 4))) begin n_err++; $display("FAIL stream_data[%0d]: got %h expected %h", i, mon_data[i], mem_model(32'(i * 4))); end
            n_vec++; if (mon_id[i] !== 4'(i)) begin n_err++; $display("FAIL stream_id[%0d]: got %h expected %h", i, mon_id[i], 4'(i)); end
            n_vec++; if (mon_last[i] !== (i == 3)) begin n_err++; $display("FAIL stream_last[%0d]: got %b expected %b", i, mon_last[i], (i == 3)); end
            n_vec++; if (mon_cyc[i] !== a + 2 + i) begin n_err++; $display("FAIL stream_cycle[%0d]: got %0d expected %0d", i, mon_cyc[i], a + 2 + i); end
        end
    endtask

    task automatic test_backpressure();
        int sent;
        clear_mon();
        rready = 1'b0;
        sent = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (sent < 8) drive(32'h100 + 32'(sent * 4), 4'(sent), (sent == 7));
            #1;
            if (beat_valid && beat_ready) sent++;
        end
        n_vec++; if (sent !== 4) begin n_err++; $display("FAIL bp_accepted: got %0d expected 4", sent); end
        n_vec++; if (beat_ready !== 1'b0) begin n_err++; $display("FAIL bp_beat_ready: got %b expected 0", beat_ready); end
        n_vec++; if (rvalid !== 1'b1) begin n_err++; $display("FAIL bp_rvalid: got %b expected 1", rvalid); end
        n_vec++; if (rid !== 4'h0) begin n_err++; $display("FAIL bp_head_id: got %h expected 0", rid); end
        n_vec++; if (rdata !== mem_model(32'h100)) begin n_err++; $display("FAIL bp_head_data: got %h expected %h", rdata, mem_model(32'h100)); end
        rready = 1'b1;
        for (int k = 0; k < 40 && sent < 8; k++) begin
            @(negedge clk);
            drive(32'h100 + 32'(sent * 4), 4'(sent), (sent == 7));
            #1;
            if (beat_ready) sent++;
        end
        @(negedge clk); idle();
        wait_beats(8, 40);
        n_vec++; if (mon_id.size() !== 8) begin n_err++; $display("FAIL bp_count: got %0d expected 8", mon_id.size()); end
        for (int i = 0; i < mon_id.size(); i++) begin
            n_vec++; if (mon_id[i] !== 4'(i)) begin n_err++; $display("FAIL bp_id[%0d]: got %h expected %h", i, mon_id[i], 4'(i)); end
            n_vec++; if (mon_data[i] !== mem_model(32'h100 + 32'(i * 4))) begin n_err++; $display("FAIL bp_data[%0d]: got %h expected %h", i, mon_data[i], mem_model(32'h100 + 32'(i * 4))); end
            n_vec++; if (mon_last[i] !== (i == 7)) begin n_err++; $display("FAIL bp_last[%0d]: got %b expected %b", i, mon_last[i], (i == 7)); end
        end
    endtask

    task automatic test_out_of_range();
        clear_mon();
        rready = 1'b1;
        @(negedge clk);
        drive(32'h0000_0FFC, 4'h5, 1'b0);
        #1;
        n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL oor_last_valid_req: got %b expected 1", mem_req); end
        @(negedge clk);
        drive(32'h0000_1000, 4'h6, 1'b1);
        #1;
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL oor_mem_req: got %b expected 0", mem_req); end
        n_vec++; if (beat_ready !== 1'b1) begin n_err++; $display("FAIL oor_beat_ready: got %b expected 1", beat_ready); end
        @(negedge clk); idle();
        wait_beats(2, 20);
        n_vec++; if (mon_id.size() !== 2) begin n_err++; $display("FAIL oor_count: got %0d expected 2", mon_id.size()); end
        if (mon_id.size() == 2) begin
            n_vec++; if (mon_resp[0] !== 2'b00) begin n_err++; $display("FAIL oor_resp0: got %b expected 00", mon_resp[0]); end
            n_vec++; if (mon_data[0] !== mem_model(32'h0FFC)) begin n_err++; $display("FAIL oor_data0: got %h expected %h", mon_data[0], mem_model(32'h0FFC)); end
            n_vec++; if (mon_resp[1] !== 2'b10) begin n_err++; $display("FAIL oor_resp1: got %b expected 10", mon_resp[1]); end
            n_vec++; if (mon_data[1] !== 32'h0) begin n_err++; $display("FAIL oor_data1: got %h expected 00000000", mon_data[1]); end
            n_vec++; if (mon_id[1] !== 4'h6) begin n_err++; $display("FAIL oor_id1: got %h expected 6", mon_id[1]); end
            n_vec++; if (mon_last[1] !== 1'b1) begin n_err++; $display("FAIL oor_last1: got %b expected 1", mon_last[1]); end
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        rready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(32'h200 + 32'(i * 4), 4'(8 + i), (i == 3));
        end
        @(negedge clk); idle();
        #1;
        n_vec++; if (dut.fifo_count_s !== 3'd3) begin n_err++; $display("FAIL rmid_count_before: got %0d expected 3", dut.fifo_count_s); end
        rstnn = 1'b0;
        @(negedge clk);
        rstnn = 1'b1;
        #1;
        n_vec++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL rmid_rvalid: got %b expected 0", rvalid); end
        n_vec++; if (dut.fifo_count_s !== 3'd0) begin n_err++; $display("FAIL rmid_count_after: got %0d expected 0", dut.fifo_count_s); end
        rready = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        n_vec++; if (mon_id.size() !== 0) begin n_err++; $display("FAIL rmid_stale_beats: got %0d expected 0", mon_id.size()); end
        n_vec++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL rmid_rvalid_late: got %b expected 0", rvalid); end
    endtask

    task automatic test_full_push_pop();
        clear_mon();
        rready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(32'h300 + 32'(i * 4), 4'(i), 1'b0);
        end
        @(negedge clk); idle(); rready = 1'b1;
        #1;
        n_vec++; if (dut.fifo_count_s !== 3'd3) begin n_err++; $display("FAIL full_count_pre: got %0d expected 3", dut.fifo_count_s); end
        n_vec++; if (beat_ready !== 1'b0) begin n_err++; $display("FAIL full_beat_ready_pre: got %b expected 0", beat_ready); end
        @(negedge clk);
        drive(32'h310, 4'h4, 1'b0);
        #1;
        n_vec++; if (dut.fifo_count_s !== 3'd3) begin n_err++; $display("FAIL full_count_pushpop: got %0d expected 3", dut.fifo_count_s); end
        n_vec++; if (beat_ready !== 1'b1) begin n_err++; $display("FAIL full_beat_ready_post: got %b expected 1", beat_ready); end
        @(negedge clk);
        drive(32'h314, 4'h5, 1'b1);
        #1;
        n_vec++; if (dut.fifo_count_s !== 3'd2) begin n_err++; $display("FAIL full_count_next: got %0d expected 2", dut.fifo_count_s); end
        @(negedge clk); idle();
        wait_beats(6, 30);
        n_vec++; if (mon_id.size() !== 6) begin n_err++; $display("FAIL full_count_total: got %0d expected 6", mon_id.size()); end
        for (int i = 0; i < mon_id.size(); i++) begin
            n_vec++; if (mon_id[i] !== 4'(i)) begin n_err++; $display("FAIL full_id[%0d]: got %h expected %h", i, mon_id[i], 4'(i)); end
            n_vec++; if (mon_data[i] !== mem_model(32'h300 + 32'(i * 4))) begin n_err++; $display("FAIL full_data[%0d]: got %h expected %h", i, mon_data[i], mem_model(32'h300 + 32'(i * 4))); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rready = 1'b0;
        rstnn  = 1'b0;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_out_of_range();
        test_reset_mid();
        test_full_push_pop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
